// File: rtl/v_hier_serdes_pkg.sv
// Shared types and helpers for the serializer/deserializer around the 1-bit leaf stage.
package v_hier_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Ceiling log2, used at elaboration for counter sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/v_hier_shreg.sv
// Parameterized shift register with parallel load, shift enable, serial input and direction select.
module v_hier_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_right,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_q
);

  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = shift_right ? {ser_in, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], ser_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

endmodule

// File: rtl/v_hier_sub_serdes.sv
// Drives a word LSB-first into the leaf stage and rebuilds it from the leaf output.
// Optional even-parity trailer bit and par_err port when V_HIER_SERDES_PARITY_EN is defined.
module v_hier_sub_serdes
  import v_hier_serdes_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int IGNORED = 0
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_out,
  output logic             frame,
  input  logic             q_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             mismatch
`ifdef V_HIER_SERDES_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_PAY = CW'(WIDTH - 1);
`ifdef V_HIER_SERDES_PARITY_EN
  localparam logic [CW-1:0] PAR_CNT = CW'(WIDTH);
`endif

  // IGNORED only configures the leaf stage; nothing in this block depends on it.
  if (IGNORED != 0) begin : g_leaf_cfg
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            a_out_q, a_out_d;
  logic            frame_q, frame_d;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH-1:0] tx_q, rx_q;
  logic            tx_load, tx_shift, rx_shift;
`ifdef V_HIER_SERDES_PARITY_EN
  logic            par_err_q, par_err_d;
`endif

  // tx rotates instead of zero-filling, so after a full word it holds the original again.
  v_hier_shreg #(.WIDTH(WIDTH)) u_tx (
    .clk        (clk),
    .rst_n      (reset_l),
    .load       (tx_load),
    .load_data  (in_data),
    .shift_en   (tx_shift),
    .shift_right(1'b1),
    .ser_in     (tx_q[0]),
    .data_q     (tx_q)
  );

  v_hier_shreg #(.WIDTH(WIDTH)) u_rx (
    .clk        (clk),
    .rst_n      (reset_l),
    .load       (1'b0),
    .load_data  ({WIDTH{1'b0}}),
    .shift_en   (rx_shift),
    .shift_right(1'b1),
    .ser_in     (q_in),
    .data_q     (rx_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_out_d     = a_out_q;
    frame_d     = frame_q;
    out_valid_d = out_valid_q;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
`ifdef V_HIER_SERDES_PARITY_EN
    par_err_d   = par_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          tx_load = 1'b1;
          cnt_d   = '0;
          a_out_d = in_data[0];
          frame_d = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
`ifdef V_HIER_SERDES_PARITY_EN
        if (cnt_q == PAR_CNT) begin
          par_err_d   = q_in ^ (^rx_q);
          a_out_d     = 1'b0;
          frame_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          rx_shift = 1'b1;
          tx_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          // Parity of a rotated word equals parity of the original.
          a_out_d  = (cnt_q == LAST_PAY) ? ^tx_q : tx_q[1];
        end
`else
        rx_shift = 1'b1;
        tx_shift = 1'b1;
        if (cnt_q == LAST_PAY) begin
          a_out_d     = 1'b0;
          frame_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          a_out_d = tx_q[1];
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_out_q     <= 1'b0;
      frame_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef V_HIER_SERDES_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_out_q     <= a_out_d;
      frame_q     <= frame_d;
      out_valid_q <= out_valid_d;
`ifdef V_HIER_SERDES_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign a_out     = a_out_q;
  assign frame     = frame_q;
  assign out_valid = out_valid_q;
  assign out_data  = rx_q;
  assign mismatch  = out_valid_q & (rx_q != tx_q);
`ifdef V_HIER_SERDES_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_v_hier_sub_serdes.sv
// Directed bench for v_hier_sub_serdes with the leaf modelled as a wire from a_out to q_in.
module tb_v_hier_sub_serdes;

  localparam int W = 8;
`ifdef V_HIER_SERDES_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_l = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         a_out;
  logic         frame;
  logic         q_in;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         mismatch;
  logic         force_en = 1'b0;
  logic         force_val = 1'b0;
`ifdef V_HIER_SERDES_PARITY_EN
  logic         par_err;
`endif
  int errors = 0;
  int checks = 0;

  // Leaf is a combinational pass-through; force_en overrides it to inject faults.
  assign q_in = force_en ? force_val : a_out;

  always #5 clk = ~clk;

  v_hier_sub_serdes #(.WIDTH(W), .IGNORED(0)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .a_out    (a_out),
    .frame    (frame),
    .q_in     (q_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .mismatch (mismatch)
`ifdef V_HIER_SERDES_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (in_ready !== 1'b1 || a_out !== 1'b0 || frame !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b a_out=%b frame=%b out_valid=%b out_data=%h mismatch=%b, expected 1 0 0 0 00 0",
               in_ready, a_out, frame, out_valid, out_data, mismatch);
    end
    tick();
    tick();
    reset_l = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || frame !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b frame=%b out_valid=%b, expected 1 0 0", in_ready, frame, out_valid);
    end
    $display("reset released");
  endtask

  task automatic test_basic;
    logic [W-1:0] d;
    d = 8'hA5;
    out_ready = 1'b1;
    start_word(d);
    for (int k = 0; k < W; k++) begin
      if (k > 0) tick();
      checks++;
      if (a_out !== d[k] || frame !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_bit%0d: a_out=%b frame=%b in_ready=%b, expected a_out=%b frame=1 in_ready=0",
                 k, a_out, frame, in_ready, d[k]);
      end
    end
    repeat (EXTRA) tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || mismatch !== 1'b0 || frame !== 1'b0 || a_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_out: out_valid=%b out_data=%h mismatch=%b frame=%b a_out=%b, expected 1 a5 0 0 0",
               out_valid, out_data, mismatch, frame, a_out);
    end
    $display("word in=%h out=%h mismatch=%b", d, out_data, mismatch);
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_fault;
    start_word(8'hFF);
    for (int k = 0; k < W; k++) begin
      if (k > 0) tick();
      force_en  = (k == 3);
      force_val = 1'b0;
    end
    force_en = 1'b0;
    repeat (EXTRA) tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hF7 || mismatch !== 1'b1) begin
      errors++;
      $display("FAIL fault_out: out_valid=%b out_data=%h mismatch=%b, expected 1 f7 1", out_valid, out_data, mismatch);
    end
    $display("word in=ff out=%h mismatch=%b (bit 3 forced low)", out_data, mismatch);
    tick();
  endtask

  task automatic test_back_to_back;
    int lowcnt;
    int n;
    logic [W-1:0] first_data;
    logic first_mm;
    logic first_seen;
    first_seen = 1'b0;
    first_data = '1;
    first_mm   = 1'b1;
    out_ready  = 1'b1;
    in_data    = 8'h00;
    in_valid   = 1'b1;
    tick();
    in_data = 8'hFF;
    lowcnt  = 0;
    while (in_ready === 1'b0 && lowcnt < 40) begin
      if (out_valid === 1'b1) begin
        first_seen = 1'b1;
        first_data = out_data;
        first_mm   = mismatch;
      end
      lowcnt++;
      tick();
    end
    checks++;
    if (lowcnt != 9 + EXTRA) begin
      errors++;
      $display("FAIL b2b_ready_gap: in_ready low for %0d cycles, expected %0d", lowcnt, 9 + EXTRA);
    end
    checks++;
    if (first_seen !== 1'b1 || first_data !== 8'h00 || first_mm !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: seen=%b out_data=%h mismatch=%b, expected 1 00 0", first_seen, first_data, first_mm);
    end
    $display("word in=00 out=%h mismatch=%b", first_data, first_mm);
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || frame !== 1'b1 || a_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: in_ready=%b frame=%b a_out=%b, expected 0 1 1", in_ready, frame, a_out);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != W + EXTRA) begin
      errors++;
      $display("FAIL b2b_second_latency: out_valid=%b after %0d cycles, expected 1 after %0d", out_valid, n, W + EXTRA);
    end
    checks++;
    if (out_data !== 8'hFF || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_data: out_data=%h mismatch=%b, expected ff 0", out_data, mismatch);
    end
    $display("word in=ff out=%h mismatch=%b", out_data, mismatch);
    tick();
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    start_word(8'h5A);
    in_valid = 1'b1;
    in_data  = 8'hC3;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b after %0d cycles, expected 1", out_valid, n);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || mismatch !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b out_data=%h mismatch=%b in_ready=%b, expected 1 5a 0 0",
                 k, out_valid, out_data, mismatch, in_ready);
      end
    end
    $display("word in=5a out=%h mismatch=%b (held 5 cycles)", out_data, mismatch);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (frame !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_capture: frame=%b in_ready=%b, expected 0 1", frame, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    start_word(8'h99);
    tick();
    tick();
    tick();
    reset_l = 1'b0;
    #1;
    checks++;
    if (a_out !== 1'b0 || frame !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: a_out=%b frame=%b out_valid=%b in_ready=%b, expected 0 0 0 1",
               a_out, frame, out_valid, in_ready);
    end
    tick();
    #2;
    reset_l = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: in_ready=%b out_valid=%b frame=%b, expected 1 0 0", in_ready, out_valid, frame);
    end
    $display("word in=99 aborted by reset");
    start_word(8'h3C);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != W + EXTRA || out_data !== 8'h3C || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next: out_valid=%b cycles=%0d out_data=%h mismatch=%b, expected 1 %0d 3c 0",
               out_valid, n, out_data, mismatch, W + EXTRA);
    end
    $display("word in=3c out=%h mismatch=%b", out_data, mismatch);
    tick();
  endtask

`ifdef V_HIER_SERDES_PARITY_EN
  task automatic test_parity;
    for (int run = 0; run < 2; run++) begin
      start_word(8'h07);
      repeat (W) tick();
      checks++;
      if (a_out !== 1'b1 || frame !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL parity_bit_run%0d: a_out=%b frame=%b out_valid=%b, expected 1 1 0", run, a_out, frame, out_valid);
      end
      force_en  = (run == 1);
      force_val = 1'b0;
      tick();
      force_en = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h07 || mismatch !== 1'b0 || par_err !== (run == 1)) begin
        errors++;
        $display("FAIL parity_out_run%0d: out_valid=%b out_data=%h mismatch=%b par_err=%b, expected 1 07 0 %0d",
                 run, out_valid, out_data, mismatch, par_err, run);
      end
      $display("word in=07 out=%h par_err=%b", out_data, par_err);
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef V_HIER_SERDES_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
